// File: rtl/unidade_busca_pkg.sv
// Shared definitions for the Redux-V instruction-fetch unit: default widths,
// the halt encoding and the fetch FSM state type.
package redux_pkg;

    localparam int LARGURA_END_PADRAO   = 8;
    localparam int LARGURA_INSTR_PADRAO = 8;
    localparam logic [7:0] INSTR_PARADA_PADRAO = 8'hFF;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        BUSCA  = 2'd1,
        PARADO = 2'd2
    } estado_t;

endpackage

// File: rtl/unidade_busca_if.sv
// Fetch-unit bundle: instruction-memory port, control inputs and the
// valid/ready handoff towards decode.
interface unidade_busca_if
    import redux_pkg::*;
#(
    parameter int LARGURA_END   = LARGURA_END_PADRAO,
    parameter int LARGURA_INSTR = LARGURA_INSTR_PADRAO
);

    logic                     iniciar;
    logic [LARGURA_END-1:0]   endereco;
    logic [LARGURA_INSTR-1:0] instrucao;
    logic                     instr_valido;
    logic [LARGURA_INSTR-1:0] instr_dado;
    logic [LARGURA_END-1:0]   instr_pc;
    logic                     instr_pronto;
    logic                     desvio_valido;
    logic [LARGURA_END-1:0]   desvio_alvo;
    logic                     parado;

    modport master (
        input  iniciar, instrucao, instr_pronto, desvio_valido, desvio_alvo,
        output endereco, instr_valido, instr_dado, instr_pc, parado
    );

    modport slave (
        output iniciar, instrucao, instr_pronto, desvio_valido, desvio_alvo,
        input  endereco, instr_valido, instr_dado, instr_pc, parado
    );

endinterface

// File: rtl/unidade_busca_fila.sv
// Two-deep FIFO holding {instruction, pc} pairs between fetch and decode;
// entry dado_p0 is always the head.
module fila_busca #(
    parameter int LARGURA = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [LARGURA-1:0] entrada,
    output logic               cheio,
    output logic               vazio,
    output logic [LARGURA-1:0] head
);

    logic [1:0]         contagem;
    logic [LARGURA-1:0] dado_p0;
    logic [LARGURA-1:0] dado_p1;
    logic               push_ok;
    logic               pop_ok;

    assign cheio   = (contagem == 2'd2);
    assign vazio   = (contagem == 2'd0);
    assign head    = dado_p0;
    assign push_ok = push && !cheio;
    assign pop_ok  = pop && !vazio;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            contagem <= 2'd0;
            dado_p0  <= '0;
            dado_p1  <= '0;
        end else if (flush) begin
            contagem <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (vazio) dado_p0 <= entrada;
                    else       dado_p1 <= entrada;
                    contagem <= contagem + 2'd1;
                end
                2'b01: begin
                    dado_p0  <= dado_p1;
                    contagem <= contagem - 2'd1;
                end
                // push_ok excludes full and pop_ok excludes empty, so exactly one entry is held here
                2'b11: dado_p0 <= entrada;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/unidade_busca.sv
// Instruction-fetch controller: owns the PC, runs the OCIOSO/BUSCA/PARADO FSM,
// handles branch redirect and feeds decode through fila_busca.
module unidade_busca
    import redux_pkg::*;
#(
    parameter int                       LARGURA_END   = LARGURA_END_PADRAO,
    parameter int                       LARGURA_INSTR = LARGURA_INSTR_PADRAO,
    parameter logic [LARGURA_END-1:0]   END_INICIAL   = '0,
    parameter logic [LARGURA_INSTR-1:0] INSTR_PARADA  = INSTR_PARADA_PADRAO
) (
    input  logic            clock,
    input  logic            reset_n,
    unidade_busca_if.master bus
);

    estado_t                              estado;
    logic [LARGURA_END-1:0]               pc;
    logic                                 cheio;
    logic                                 vazio;
    logic                                 busca;
    logic                                 retira;
    logic [LARGURA_INSTR+LARGURA_END-1:0] cabeca;

    // A redirect suppresses both push and pop in its cycle.
    assign busca  = (estado == BUSCA) && !cheio && !bus.desvio_valido;
    assign retira = !vazio && bus.instr_pronto && !bus.desvio_valido;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc     <= END_INICIAL;
            estado <= OCIOSO;
        end else if (bus.desvio_valido) begin
            pc     <= bus.desvio_alvo;
            estado <= BUSCA;
        end else if (bus.iniciar && estado == OCIOSO) begin
            pc     <= END_INICIAL;
            estado <= BUSCA;
        end else if (busca) begin
            pc <= pc + LARGURA_END'(1);
            if (bus.instrucao == INSTR_PARADA) estado <= PARADO;
        end
    end

    fila_busca #(
        .LARGURA(LARGURA_INSTR + LARGURA_END)
    ) u_fila (
        .clock  (clock),
        .reset_n(reset_n),
        .push   (busca),
        .pop    (retira),
        .flush  (bus.desvio_valido),
        .entrada({bus.instrucao, pc}),
        .cheio  (cheio),
        .vazio  (vazio),
        .head   (cabeca)
    );

    assign bus.endereco              = pc;
    assign bus.instr_valido          = !vazio;
    assign {bus.instr_dado, bus.instr_pc} = cabeca;
    assign bus.parado                = (estado == PARADO);

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: table-driven start-up/backpressure/redirect, hand
// sequences for halt, wrap and async reset, then random traffic vs a queue model.
module tb_unidade_busca;

    logic clock;
    logic reset_n;
    logic [7:0] mem [256];

    unidade_busca_if bus ();

    unidade_busca dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    assign bus.instrucao = mem[bus.endereco];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] pc;
    } ent_t;

    localparam int M_OCIOSO = 0;
    localparam int M_BUSCA  = 1;
    localparam int M_PARADO = 2;

    ent_t m_q[$];
    int   m_pc;
    int   m_modo;

    int total;
    int falhas;

    typedef struct {
        logic       ini;
        logic       dv;
        logic [7:0] alvo;
        logic       pr;
        logic [7:0] e_end;
        logic       e_vld;
        logic [7:0] e_pc;
        logic [7:0] e_dado;
        logic       e_par;
    } vetor_t;

    vetor_t tab[10];

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        total++;
        if (atual !== esperado) begin
            falhas++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
        end
    endtask

    function automatic void modelo_reset();
        m_q.delete();
        m_pc   = 0;
        m_modo = M_OCIOSO;
    endfunction

    function automatic void modelo_passo(input logic ini, input logic dv,
                                         input logic [7:0] alvo, input logic pr);
        ent_t novo;
        bit   tira;
        bit   poe;
        if (dv) begin
            m_q.delete();
            m_pc   = int'(alvo);
            m_modo = M_BUSCA;
        end else if (ini && m_modo == M_OCIOSO) begin
            m_pc   = 0;
            m_modo = M_BUSCA;
        end else begin
            tira       = (m_q.size() > 0) && pr;
            poe        = (m_modo == M_BUSCA) && (m_q.size() < 2);
            novo.instr = mem[m_pc];
            novo.pc    = 8'(m_pc);
            if (tira) void'(m_q.pop_front());
            if (poe) begin
                m_q.push_back(novo);
                m_pc = (m_pc + 1) % 256;
                if (novo.instr == 8'hFF) m_modo = M_PARADO;
            end
        end
    endfunction

    task automatic comparar(input string tag);
        chk({tag, ".endereco"}, 32'(bus.endereco), 32'(m_pc));
        chk({tag, ".valido"}, 32'(bus.instr_valido), 32'(m_q.size() > 0));
        chk({tag, ".parado"}, 32'(bus.parado), 32'(m_modo == M_PARADO));
        if (m_q.size() > 0) begin
            chk({tag, ".instr_pc"}, 32'(bus.instr_pc), 32'(m_q[0].pc));
            chk({tag, ".instr_dado"}, 32'(bus.instr_dado), 32'(m_q[0].instr));
        end
    endtask

    // Called at a falling edge: drive inputs, advance one rising edge, check at next fall.
    task automatic passo(input string tag, input logic ini, input logic dv,
                         input logic [7:0] alvo, input logic pr);
        bus.iniciar       = ini;
        bus.desvio_valido = dv;
        bus.desvio_alvo   = alvo;
        bus.instr_pronto  = pr;
        @(posedge clock);
        modelo_passo(ini, dv, alvo, pr);
        @(negedge clock);
        comparar(tag);
    endtask

    task automatic reset_assincrono(input string tag);
        #2 reset_n = 1'b0;
        #1;
        chk({tag, ".valido"}, 32'(bus.instr_valido), 32'd0);
        chk({tag, ".endereco"}, 32'(bus.endereco), 32'd0);
        chk({tag, ".parado"}, 32'(bus.parado), 32'd0);
        modelo_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        total  = 0;
        falhas = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[7] = 8'hFF;

        //              ini   dv    alvo   pr    end     vld   pc      dado    par
        tab[0] = '{1'b1, 1'b0, 8'd0,   1'b0, 8'd0,   1'b0, 8'd0,   8'd0,   1'b0};
        tab[1] = '{1'b0, 1'b0, 8'd0,   1'b0, 8'd1,   1'b1, 8'd0,   8'd0,   1'b0};
        tab[2] = '{1'b0, 1'b0, 8'd0,   1'b0, 8'd2,   1'b1, 8'd0,   8'd0,   1'b0};
        tab[3] = '{1'b0, 1'b0, 8'd0,   1'b0, 8'd2,   1'b1, 8'd0,   8'd0,   1'b0};
        tab[4] = '{1'b0, 1'b0, 8'd0,   1'b1, 8'd2,   1'b1, 8'd1,   8'd1,   1'b0};
        tab[5] = '{1'b0, 1'b0, 8'd0,   1'b1, 8'd3,   1'b1, 8'd2,   8'd2,   1'b0};
        tab[6] = '{1'b0, 1'b0, 8'd0,   1'b1, 8'd4,   1'b1, 8'd3,   8'd3,   1'b0};
        tab[7] = '{1'b0, 1'b0, 8'd0,   1'b1, 8'd5,   1'b1, 8'd4,   8'd4,   1'b0};
        tab[8] = '{1'b0, 1'b1, 8'd100, 1'b1, 8'd100, 1'b0, 8'd0,   8'd0,   1'b0};
        tab[9] = '{1'b0, 1'b0, 8'd0,   1'b1, 8'd101, 1'b1, 8'd100, 8'd100, 1'b0};

        reset_n           = 1'b0;
        bus.iniciar       = 1'b0;
        bus.desvio_valido = 1'b0;
        bus.desvio_alvo   = 8'd0;
        bus.instr_pronto  = 1'b0;
        modelo_reset();
        repeat (2) @(negedge clock);
        chk("reset.endereco", 32'(bus.endereco), 32'd0);
        chk("reset.valido", 32'(bus.instr_valido), 32'd0);
        chk("reset.dado", 32'(bus.instr_dado), 32'd0);
        chk("reset.pc", 32'(bus.instr_pc), 32'd0);
        chk("reset.parado", 32'(bus.parado), 32'd0);
        reset_n = 1'b1;

        // Start-up, backpressure, gapless drain and redirect at endereco=5
        for (int i = 0; i < 10; i++) begin
            string t;
            t = $sformatf("tab%0d", i);
            passo(t, tab[i].ini, tab[i].dv, tab[i].alvo, tab[i].pr);
            chk({t, ".x_endereco"}, 32'(bus.endereco), 32'(tab[i].e_end));
            chk({t, ".x_valido"}, 32'(bus.instr_valido), 32'(tab[i].e_vld));
            chk({t, ".x_parado"}, 32'(bus.parado), 32'(tab[i].e_par));
            if (tab[i].e_vld) begin
                chk({t, ".x_pc"}, 32'(bus.instr_pc), 32'(tab[i].e_pc));
                chk({t, ".x_dado"}, 32'(bus.instr_dado), 32'(tab[i].e_dado));
            end
        end

        // Halt at address 7, then resume via redirect to 20
        passo("halt0", 1'b0, 1'b1, 8'd5, 1'b1);
        passo("halt1", 1'b0, 1'b0, 8'd0, 1'b1);
        passo("halt2", 1'b0, 1'b0, 8'd0, 1'b1);
        passo("halt3", 1'b0, 1'b0, 8'd0, 1'b1);
        chk("halt3.x_pc", 32'(bus.instr_pc), 32'd7);
        chk("halt3.x_dado", 32'(bus.instr_dado), 32'hFF);
        chk("halt3.x_parado", 32'(bus.parado), 32'd1);
        chk("halt3.x_endereco", 32'(bus.endereco), 32'd8);
        for (int i = 0; i < 3; i++) begin
            passo($sformatf("halt_idle%0d", i), 1'b0, 1'b0, 8'd0, 1'b1);
            chk($sformatf("halt_idle%0d.x_valido", i), 32'(bus.instr_valido), 32'd0);
            chk($sformatf("halt_idle%0d.x_endereco", i), 32'(bus.endereco), 32'd8);
        end
        passo("resume0", 1'b0, 1'b1, 8'd20, 1'b1);
        chk("resume0.x_parado", 32'(bus.parado), 32'd0);
        chk("resume0.x_endereco", 32'(bus.endereco), 32'd20);
        passo("resume1", 1'b0, 1'b0, 8'd0, 1'b1);
        chk("resume1.x_pc", 32'(bus.instr_pc), 32'd20);

        // PC wrap 254,255,0,1
        mem[255] = 8'h55;
        passo("wrap0", 1'b0, 1'b1, 8'd254, 1'b1);
        begin
            logic [7:0] esperado_wrap [4];
            esperado_wrap = '{8'd254, 8'd255, 8'd0, 8'd1};
            for (int i = 0; i < 4; i++) begin
                passo($sformatf("wrap%0d", i + 1), 1'b0, 1'b0, 8'd0, 1'b1);
                chk($sformatf("wrap%0d.x_pc", i + 1), 32'(bus.instr_pc), 32'(esperado_wrap[i]));
            end
        end

        // Async reset with two entries queued, then idle until iniciar
        for (int i = 0; i < 3; i++) passo($sformatf("fill%0d", i), 1'b0, 1'b0, 8'd0, 1'b0);
        chk("fill.x_valido", 32'(bus.instr_valido), 32'd1);
        reset_assincrono("areset");
        for (int i = 0; i < 3; i++) begin
            passo($sformatf("ocioso%0d", i), 1'b0, 1'b0, 8'd0, 1'b1);
            chk($sformatf("ocioso%0d.x_endereco", i), 32'(bus.endereco), 32'd0);
            chk($sformatf("ocioso%0d.x_valido", i), 32'(bus.instr_valido), 32'd0);
        end
        passo("reinicio", 1'b1, 1'b0, 8'd0, 1'b1);

        // Random traffic against the queue model
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        for (int i = 0; i < 400; i++) begin
            logic ini, dv, pr;
            logic [7:0] alvo;
            ini  = ($urandom_range(0, 7) == 0);
            dv   = ($urandom_range(0, 11) == 0);
            pr   = ($urandom_range(0, 3) != 0);
            alvo = 8'($urandom_range(0, 255));
            if (i == 200) reset_assincrono("rnd_areset");
            passo($sformatf("rnd%0d", i), ini, dv, alvo, pr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", total, falhas);
        $finish;
    end

endmodule

// File: doc/unidade_busca.md
Name: unidade_busca

Overview:
- Instruction-fetch controller for the Redux-V core. Owns the program counter and drives the address input of memoria_instrucoes (8-bit address in, 8-bit instruction out, combinational read).
- Buffers fetched instructions in a 2-entry queue and hands them to the decode stage over a valid/ready handshake.
- Handles start-up, branch redirect (flush and reload) and halt.

Parameters:
- LARGURA_END, 8, PC / instruction-memory address width.
- LARGURA_INSTR, 8, instruction width.
- END_INICIAL, 8'd0, PC value loaded at reset and on iniciar.
- INSTR_PARADA, 8'hFF, instruction encoding that halts fetching.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- iniciar  in  1  one-cycle start pulse; honoured only in OCIOSO.
- endereco  out  LARGURA_END  address to memoria_instrucoes; equals the PC register.
- instrucao  in  LARGURA_INSTR  instruction from memoria_instrucoes; valid in the same cycle as endereco.
- instr_valido  out  1  queue head is valid.
- instr_dado  out  LARGURA_INSTR  queue-head instruction.
- instr_pc  out  LARGURA_END  address that queue-head instruction was fetched from.
- instr_pronto  in  1  decode accepts head; a pop happens when instr_valido && instr_pronto.
- desvio_valido  in  1  redirect request, one cycle.
- desvio_alvo  in  LARGURA_END  redirect target.
- parado  out  1  high in state PARADO.

Behaviour:
- Reset (async on reset_n=0):
  - pc=END_INICIAL, queue count=0, state=OCIOSO.
  - Outputs: instr_valido=0, instr_dado=0, instr_pc=0, parado=0, endereco=END_INICIAL.
- Reset asserted mid-operation discards the queue and any in-flight redirect immediately.
- FSM states: OCIOSO, BUSCA, PARADO.
  - OCIOSO: no fetch. iniciar=1 -> BUSCA with pc=END_INICIAL.
  - BUSCA: fetch whenever count<2. A fetch pushes {instrucao, pc} into the queue and sets pc<=pc+1.
  - BUSCA: if the pushed instrucao==INSTR_PARADA, it is still enqueued and state goes to PARADO; pc still increments.
  - PARADO: no fetch. Queue keeps draining normally.
- Redirect (desvio_valido=1) in any state, including OCIOSO and PARADO:
  - Queue flushed (count<=0), pc<=desvio_alvo, state<=BUSCA.
  - No push and no pop take effect that cycle, even if instr_pronto=1.
- Priority order: reset_n > desvio_valido > iniciar > push/pop.
- PC arithmetic is modulo 2^LARGURA_END: 8'd255+1 wraps to 8'd0 with no flag; fetching continues.
- Queue is a 2-entry FIFO:
  - Push is allowed only when the registered count<2. It does not depend on a same-cycle pop.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pop when empty cannot occur (instr_valido=0).
- Latency and throughput:
  - Instruction fetched in cycle N appears on instr_dado/instr_valido in cycle N+1.
  - Steady state with instr_pronto held at 1: one instruction per cycle.
  - With instr_pronto held at 0: fetching stops after 2 entries, and pc holds at first-unfetched address.
- Outputs are registered or derived from registered state only. No combinational path exists from any input to any output.

Decomposition:
- Package redux_pkg holds:
  - FSM state enum (OCIOSO/BUSCA/PARADO).
  - LARGURA_END and LARGURA_INSTR defaults.
  - INSTR_PARADA constant.
- One natural sub-module: fila_busca, a parameterised 2-deep FIFO storing {instr, pc}.
  - Ports: push, pop, flush, cheio, vazio, head.
- unidade_busca contains the PC, the FSM and the redirect logic.

Test Plan:
- Start-up: bench memory model has mem[a]=a. Hold reset_n=0, release, pulse iniciar, hold instr_pronto=1.
  - Expect endereco to go 0,1,2,... in successive cycles.
  - Expect instr_dado=instr_pc=0,1,2,... one cycle later.
  - parado=0 throughout.
- Backpressure: instr_pronto=0 after start.
  - Expect count to saturate at 2 with entries 0 and 1 held, and endereco frozen at 2.
  - Raise instr_pronto and expect a gapless stream 0,1,2,3.
- Redirect: while streaming, at the cycle endereco=5, assert desvio_valido with desvio_alvo=8'd100 and instr_pronto=1.
  - Next cycle: instr_valido=0, endereco=100.
  - Following cycle: instr_pc=100, with no stale entry (4 or 5) ever popped after the redirect.
- Halt: set mem[7]=8'hFF.
  - Expect the instruction at address 7 to be delivered with instr_dado=8'hFF, followed by no further entries.
  - Expect parado=1 from the cycle after the fetch of 7, and endereco=8.
  - Then desvio_valido with desvio_alvo=8'd20: expect parado=0 and fetch resuming at 20.
- Wrap: redirect to 8'd254 with instr_pronto=1.
  - Expect instr_pc sequence 254,255,0,1.
- Async reset mid-stream: drop reset_n between clock edges with 2 entries queued.
  - Expect instr_valido=0 and endereco=0 immediately, without waiting for a clock edge.
  - Expect state OCIOSO (no fetch) until iniciar.
